// File: rtl/fetch_sequencer.sv
// Four-state instruction sequencer: fetches from a 16-entry ROM, decodes, strobes the datapath, handles jmp/br/halt.
// Optional build macro FETCH_SEQ_RETIRE_CNT_EN adds a 16-bit retired-instruction counter output.
module fetch_sequencer #(
   parameter logic [3:0] PC_RESET = 4'd0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        run,
   output logic [3:0]  rom_addr,
   input  logic [15:0] rom_instr,
   input  logic        zero_flag,
   input  logic        dp_busy,
   output logic [3:0]  op,
   output logic [2:0]  rd,
   output logic [2:0]  rs,
   output logic [7:0]  imm,
   output logic        exec_en,
   output logic        halted,
`ifdef FETCH_SEQ_RETIRE_CNT_EN
   output logic [15:0] retire_cnt,
`endif
   output logic [3:0]  pc
);

   localparam logic [3:0] OP_JMP  = 4'b1000;
   localparam logic [3:0] OP_BR   = 4'b1100;
   localparam logic [3:0] OP_HALT = 4'b1111;

   typedef enum logic [1:0] {FETCH, DECODE, EXEC, HALT} state_t;

   state_t      state_reg, state_next;
   logic [3:0]  pc_reg, pc_next;
   logic [15:0] ir_reg, ir_next;
   logic [3:0]  op_reg, op_next;
   logic [2:0]  rd_reg, rd_next;
   logic [2:0]  rs_reg, rs_next;
   logic [7:0]  imm_reg, imm_next;
   logic        exec_en_reg, exec_en_next;
   logic        halted_reg, halted_next;
   logic        exec_exit;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg   <= FETCH;
         pc_reg      <= PC_RESET;
         ir_reg      <= '0;
         op_reg      <= '0;
         rd_reg      <= '0;
         rs_reg      <= '0;
         imm_reg     <= '0;
         exec_en_reg <= 1'b0;
         halted_reg  <= 1'b0;
      end else begin
         state_reg   <= state_next;
         pc_reg      <= pc_next;
         ir_reg      <= ir_next;
         op_reg      <= op_next;
         rd_reg      <= rd_next;
         rs_reg      <= rs_next;
         imm_reg     <= imm_next;
         exec_en_reg <= exec_en_next;
         halted_reg  <= halted_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      pc_next      = pc_reg;
      ir_next      = ir_reg;
      op_next      = op_reg;
      rd_next      = rd_reg;
      rs_next      = rs_reg;
      imm_next     = imm_reg;
      exec_en_next = 1'b0;
      halted_next  = halted_reg;
      exec_exit    = 1'b0;
      case (state_reg)
         FETCH: begin
            if (run) begin
               ir_next    = rom_instr;
               state_next = DECODE;
            end
         end
         DECODE: begin
            op_next      = ir_reg[15:12];
            rd_next      = ir_reg[11:9];
            rs_next      = ir_reg[8:6];
            imm_next     = ir_reg[7:0];
            // The strobe is registered here so it is high for exactly the first EXEC cycle.
            exec_en_next = (ir_reg[15:12] != OP_HALT);
            state_next   = EXEC;
         end
         EXEC: begin
            if (!dp_busy) begin
               exec_exit = 1'b1;
               if (op_reg == OP_HALT) begin
                  halted_next = 1'b1;
                  state_next  = HALT;
               end else begin
                  state_next = FETCH;
                  if (op_reg == OP_JMP || (op_reg == OP_BR && zero_flag))
                     pc_next = ir_reg[11:8];
                  else
                     pc_next = pc_reg + 4'd1;
               end
            end
         end
         HALT: begin
            state_next = HALT;
         end
         default: state_next = FETCH;
      endcase
   end

`ifdef FETCH_SEQ_RETIRE_CNT_EN
   logic [15:0] retire_cnt_reg;

   always_ff @(posedge clk) begin
      if (!rst_n)
         retire_cnt_reg <= '0;
      else if (exec_exit)
         retire_cnt_reg <= retire_cnt_reg + 16'd1;
   end

   assign retire_cnt = retire_cnt_reg;
`endif

   assign rom_addr = pc_reg;
   assign pc       = pc_reg;
   assign op       = op_reg;
   assign rd       = rd_reg;
   assign rs       = rs_reg;
   assign imm      = imm_reg;
   assign exec_en  = exec_en_reg;
   assign halted   = halted_reg;

endmodule
